// File: rtl/hub_leaf_router_pkg.sv
// rtl/hub_leaf_router_pkg.sv - shared id/port helpers for hub_leaf_router
package hub_leaf_router_pkg;

    function automatic int unsigned port_idx_width(input int unsigned leaf_count);
        return (leaf_count < 1) ? 1 : $clog2(leaf_count + 1);
    endfunction

    function automatic int unsigned broadcast_id(input int unsigned fpgaid_width);
        return (32'd1 << fpgaid_width) - 32'd1;
    endfunction

    // Caller passes the top 32 bits of the message; the id is left-aligned there.
    function automatic int unsigned dest_field(input logic [31:0] msg_top,
                                               input int unsigned fpgaid_width);
        return msg_top >> (32 - fpgaid_width);
    endfunction

endpackage

// File: rtl/hub_leaf_router_in_fifo.sv
// rtl/hub_leaf_router_in_fifo.sv - per-port synchronous input FIFO (router_in_fifo)
module router_in_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] push_data,
    input  logic             push_valid,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_valid && !full) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hub_leaf_router.sv
// rtl/hub_leaf_router.sv - hub message router across local port and leaf links; optional ROUTER_STATS_EN
module hub_leaf_router
    import hub_leaf_router_pkg::*;
#(
    parameter int LEAF_COUNT              = 2,
    parameter int FPGAID_WIDTH            = 2,
    parameter int HUB_FIFO_PHYSICAL_WIDTH = 64,
    parameter int IN_FIFO_DEPTH           = 4
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic [(LEAF_COUNT+1)*HUB_FIFO_PHYSICAL_WIDTH-1:0] in_data,
    input  logic [LEAF_COUNT:0]                               in_valid,
    output logic [LEAF_COUNT:0]                               in_ready,
    output logic [(LEAF_COUNT+1)*HUB_FIFO_PHYSICAL_WIDTH-1:0] out_data,
    output logic [LEAF_COUNT:0]                               out_valid,
    input  logic [LEAF_COUNT:0]                               out_ready,
    output logic                                              has_flying_messages,
    output logic                                              bad_dest_error
`ifdef ROUTER_STATS_EN
    ,
    output logic [(LEAF_COUNT+1)*16-1:0]                      delivered_count
`endif
);
    localparam int NP = LEAF_COUNT + 1;
    localparam int W  = HUB_FIFO_PHYSICAL_WIDTH;
    localparam int PW = port_idx_width(LEAF_COUNT);
    localparam logic [FPGAID_WIDTH-1:0] BCAST_ID = FPGAID_WIDTH'(broadcast_id(FPGAID_WIDTH));
    localparam logic [FPGAID_WIDTH-1:0] MAX_ID   = FPGAID_WIDTH'(LEAF_COUNT);

    logic [W-1:0]            head [NP];
    logic [NP-1:0]           empty;
    logic [NP-1:0]           full;
    logic [NP-1:0]           pop;
    logic [FPGAID_WIDTH-1:0] head_id [NP];
    logic [NP-1:0]           dest_mask [NP];
    logic [NP-1:0]           head_bad;
    logic [NP-1:0]           port_free;
    logic [NP-1:0]           grant;
    logic [NP-1:0]           claimed;
    logic [PW-1:0]           out_sel [NP];
    logic [PW-1:0]           first_grant;
    logic [PW-1:0]           rr_ptr;
    logic                    any_grant;
    int                      idx;

    for (genvar p = 0; p < NP; p++) begin : g_in
        router_in_fifo #(
            .WIDTH (W),
            .DEPTH (IN_FIFO_DEPTH)
        ) u_fifo (
            .clk        (clk),
            .reset      (reset),
            .push_data  (in_data[p*W +: W]),
            .push_valid (in_valid[p]),
            .pop        (pop[p]),
            .head       (head[p]),
            .full       (full[p]),
            .empty      (empty[p])
        );
    end

    assign in_ready  = ~full;
    assign port_free = ~out_valid | out_ready;

    always_comb begin
        for (int p = 0; p < NP; p++) begin
            head_id[p]   = FPGAID_WIDTH'(dest_field(head[p][W-1 -: 32], FPGAID_WIDTH));
            dest_mask[p] = '0;
            head_bad[p]  = 1'b0;
            if (head_id[p] == BCAST_ID) begin
                dest_mask[p]    = '1;
                dest_mask[p][p] = 1'b0;
            end else if (head_id[p] <= MAX_ID && head_id[p] != FPGAID_WIDTH'(p)) begin
                dest_mask[p][head_id[p]] = 1'b1;
            end else begin
                head_bad[p] = 1'b1;
            end
        end
    end

    // Single round-robin pass; a head is granted only if every destination is free and unclaimed,
    // which makes broadcasts all-or-nothing.
    always_comb begin
        claimed     = '0;
        grant       = '0;
        any_grant   = 1'b0;
        first_grant = '0;
        idx         = 0;
        for (int o = 0; o < NP; o++) out_sel[o] = '0;
        for (int k = 0; k < NP; k++) begin
            idx = (int'(rr_ptr) + k) % NP;
            if (!empty[idx] && !head_bad[idx] &&
                ((dest_mask[idx] & ~(port_free & ~claimed)) == '0)) begin
                grant[idx] = 1'b1;
                claimed    = claimed | dest_mask[idx];
                if (!any_grant) begin
                    any_grant   = 1'b1;
                    first_grant = idx[PW-1:0];
                end
                for (int o = 0; o < NP; o++) begin
                    if (dest_mask[idx][o]) out_sel[o] = idx[PW-1:0];
                end
            end
        end
    end

    // Unroutable heads are discarded independently of the allocator.
    assign pop = grant | (~empty & head_bad);

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid           <= '0;
            out_data            <= '0;
            rr_ptr              <= '0;
            has_flying_messages <= 1'b0;
            bad_dest_error      <= 1'b0;
        end else begin
            for (int o = 0; o < NP; o++) begin
                if (claimed[o]) begin
                    out_valid[o]       <= 1'b1;
                    out_data[o*W +: W] <= head[out_sel[o]];
                end else if (out_ready[o]) begin
                    out_valid[o] <= 1'b0;
                end
            end
            if (any_grant) begin
                rr_ptr <= (first_grant == PW'(NP - 1)) ? '0 : first_grant + 1'b1;
            end
            if (|(~empty & head_bad)) begin
                bad_dest_error <= 1'b1;
            end
            has_flying_messages <= (|(~empty)) | (|out_valid);
        end
    end

`ifdef ROUTER_STATS_EN
    logic [15:0] stat_cnt [NP];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int o = 0; o < NP; o++) stat_cnt[o] <= '0;
        end else begin
            for (int o = 0; o < NP; o++) begin
                if (out_valid[o] && out_ready[o] && stat_cnt[o] != 16'hFFFF) begin
                    stat_cnt[o] <= stat_cnt[o] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        for (int o = 0; o < NP; o++) delivered_count[o*16 +: 16] = stat_cnt[o];
    end
`endif

endmodule

// File: tb/tb_hub_leaf_router.sv
// tb/tb_hub_leaf_router.sv - self-checking bench for hub_leaf_router
module tb_hub_leaf_router;
    localparam int NP = 3;
    localparam int W  = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic [NP*W-1:0] in_data;
    logic [NP-1:0]   in_valid;
    logic [NP-1:0]   in_ready;
    logic [NP*W-1:0] out_data;
    logic [NP-1:0]   out_valid;
    logic [NP-1:0]   out_ready;
    logic            has_flying_messages;
    logic            bad_dest_error;
`ifdef ROUTER_STATS_EN
    logic [NP*16-1:0] delivered_count;
`endif

    hub_leaf_router dut (
        .clk                 (clk),
        .reset               (reset),
        .in_data             (in_data),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .out_data            (out_data),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .has_flying_messages (has_flying_messages),
        .bad_dest_error      (bad_dest_error)
`ifdef ROUTER_STATS_EN
        ,
        .delivered_count     (delivered_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          src;
        logic [1:0]  id;
        logic [31:0] payload;
        logic [2:0]  exp_mask;
    } vec_t;

    vec_t        vecs [7];
    logic [63:0] sb [9][$];
    bit          bad_model;
    int unsigned seq;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mk_msg(input logic [1:0] id, input int src, input logic [31:0] pl);
        return {id, 2'b00, 2'(src), 26'h0, pl};
    endfunction

    function automatic logic [63:0] out_of(input int o);
        return out_data[o*W +: W];
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        out_ready = '1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic model_push(input int p, input logic [63:0] d);
        int id;
        id = int'(d[63:62]);
        if (id == 3) begin
            for (int o = 0; o < NP; o++) if (o != p) sb[p*NP + o].push_back(d);
        end else if (id != p) begin
            sb[p*NP + id].push_back(d);
        end else begin
            bad_model = 1'b1;
        end
    endtask

    task automatic model_check(input int o, input logic [63:0] d);
        int s;
        s = int'(d[59:58]);
        checks++;
        if (s >= NP || sb[s*NP + o].size() == 0) begin
            errors++;
            $display("FAIL rand_unexpected port=%0d actual=%h required=none", o, d);
        end else begin
            logic [63:0] e;
            e = sb[s*NP + o].pop_front();
            if (d !== e) begin
                errors++;
                $display("FAIL rand_data port=%0d actual=%h required=%h", o, d, e);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{src: 1, id: 2'd2, payload: 32'hA5,       exp_mask: 3'b100};
        vecs[1] = '{src: 0, id: 2'd1, payload: 32'h11,       exp_mask: 3'b010};
        vecs[2] = '{src: 2, id: 2'd0, payload: 32'h22,       exp_mask: 3'b001};
        vecs[3] = '{src: 0, id: 2'd3, payload: 32'h3333,     exp_mask: 3'b110};
        vecs[4] = '{src: 1, id: 2'd3, payload: 32'h4444,     exp_mask: 3'b101};
        vecs[5] = '{src: 2, id: 2'd3, payload: 32'h5555,     exp_mask: 3'b011};
        vecs[6] = '{src: 1, id: 2'd0, payload: 32'hDEADBEEF, exp_mask: 3'b001};

        do_reset();
        chk("reset_in_ready", 64'(in_ready), 64'h7);
        chk("reset_out_valid", 64'(out_valid), 64'h0);
        chk("reset_out_data", out_of(0) | out_of(1) | out_of(2), 64'h0);
        chk("reset_flying", 64'(has_flying_messages), 64'h0);
        chk("reset_bad", 64'(bad_dest_error), 64'h0);

        // Isolated vectors: out_valid appears exactly one edge after acceptance.
        for (int v = 0; v < 7; v++) begin
            logic [63:0] m;
            m = mk_msg(vecs[v].id, vecs[v].src, vecs[v].payload);
            in_valid = '0;
            in_valid[vecs[v].src] = 1'b1;
            in_data[vecs[v].src*W +: W] = m;
            tick();
            in_valid = '0;
            chk($sformatf("vec%0d_early", v), 64'(out_valid), 64'h0);
            tick();
            chk($sformatf("vec%0d_mask", v), 64'(out_valid), 64'(vecs[v].exp_mask));
            for (int o = 0; o < NP; o++) begin
                if (vecs[v].exp_mask[o]) chk($sformatf("vec%0d_data%0d", v, o), out_of(o), m);
            end
            chk($sformatf("vec%0d_flying", v), 64'(has_flying_messages), 64'h1);
            tick();
            tick();
        end
        chk("vec_no_bad", 64'(bad_dest_error), 64'h0);
        chk("vec_idle_flying", 64'(has_flying_messages), 64'h0);

        // Broadcast blocked by a busy port 2 must not partially deliver to port 1.
        begin
            logic [63:0] ma, mb;
            ma = mk_msg(2'd2, 0, 32'hAAAA);
            mb = mk_msg(2'd3, 0, 32'hBBBB);
            out_ready = 3'b011;
            in_valid  = 3'b001;
            in_data[0 +: W] = ma;
            tick();
            in_data[0 +: W] = mb;
            tick();
            in_valid = '0;
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("bcast_hold%0d", i), 64'(out_valid), 64'h4);
                if (i < 2) tick();
            end
            out_ready = '1;
            tick();
            chk("bcast_valid", 64'(out_valid), 64'h6);
            chk("bcast_data1", out_of(1), mb);
            chk("bcast_data2", out_of(2), mb);
            tick();
            tick();
        end

        // Contention: ports 1 and 2 both stream to port 0 from rr_ptr=0.
        do_reset();
        begin
            int n, n1, got;
            n = 0; n1 = 0;
            in_valid = 3'b110;
            for (int c = 0; c < 40 && n < 8; c++) begin
                in_data[1*W +: W] = mk_msg(2'd0, 1, 32'(c));
                in_data[2*W +: W] = mk_msg(2'd0, 2, 32'(c));
                tick();
                if (out_valid[0]) begin
                    got = int'(out_of(0)[59:58]);
                    chk($sformatf("cont_order%0d", n), 64'(got), 64'((n % 2 == 0) ? 1 : 2));
                    if (got == 1) n1++;
                    n++;
                end
            end
            chk("cont_total", 64'(n), 64'd8);
            chk("cont_src1_count", 64'(n1), 64'd4);
            in_valid = '0;
        end

        // Backpressure: one in the out register plus four buffered, then in_ready drops.
        do_reset();
        begin
            logic [63:0] mq [5];
            int n;
            out_ready = 3'b000;
            for (int k = 0; k < 5; k++) begin
                mq[k] = mk_msg(2'd0, 1, 32'h100 + 32'(k));
                in_valid = 3'b010;
                in_data[1*W +: W] = mq[k];
                chk($sformatf("bp_ready%0d", k), 64'(in_ready[1]), 64'h1);
                tick();
            end
            in_valid = '0;
            chk("bp_full", 64'(in_ready[1]), 64'h0);
            chk("bp_head_out", out_of(0), mq[0]);
            out_ready = '1;
            n = 0;
            for (int c = 0; c < 20 && n < 5; c++) begin
                if (out_valid[0]) begin
                    chk($sformatf("bp_order%0d", n), out_of(0), mq[n]);
                    n++;
                end
                tick();
            end
            chk("bp_count", 64'(n), 64'd5);
            chk("bp_ready_back", 64'(in_ready[1]), 64'h1);
        end

        // Self-addressed message is dropped and the error flag is sticky.
        in_valid = 3'b100;
        in_data[2*W +: W] = mk_msg(2'd2, 2, 32'h5E1F);
        tick();
        in_valid = '0;
        tick();
        tick();
        chk("bad_no_out", 64'(out_valid), 64'h0);
        chk("bad_flag", 64'(bad_dest_error), 64'h1);
        tick();
        tick();
        chk("bad_sticky", 64'(bad_dest_error), 64'h1);

        // Reset with full FIFOs and loaded outputs.
        out_ready = '0;
        in_valid  = '1;
        for (int c = 0; c < 6; c++) begin
            in_data[0*W +: W] = mk_msg(2'd1, 0, 32'(c));
            in_data[1*W +: W] = mk_msg(2'd2, 1, 32'(c));
            in_data[2*W +: W] = mk_msg(2'd0, 2, 32'(c));
            tick();
        end
        chk("mid_full", 64'(in_ready), 64'h0);
        chk("mid_busy", 64'(out_valid), 64'h7);
        reset    = 1'b1;
        in_valid = '0;
        tick();
        chk("mid_in_ready", 64'(in_ready), 64'h7);
        chk("mid_out_valid", 64'(out_valid), 64'h0);
        chk("mid_out_data", out_of(0) | out_of(1) | out_of(2), 64'h0);
        chk("mid_flying", 64'(has_flying_messages), 64'h0);
        chk("mid_bad_clear", 64'(bad_dest_error), 64'h0);
        reset = 1'b0;
        tick();

        // Randomized traffic against the scoreboard.
        bad_model = 1'b0;
        seq = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int p = 0; p < NP; p++) begin
                in_valid[p] = ($urandom_range(0, 1) == 1);
                in_data[p*W +: W] = mk_msg(2'($urandom_range(0, 3)), p, seq);
                seq++;
                out_ready[p] = ($urandom_range(0, 3) != 0);
            end
            for (int p = 0; p < NP; p++) if (in_valid[p] && in_ready[p]) model_push(p, in_data[p*W +: W]);
            for (int o = 0; o < NP; o++) if (out_valid[o] && out_ready[o]) model_check(o, out_of(o));
            tick();
        end
        in_valid  = '0;
        out_ready = '1;
        begin
            int pending;
            bit done;
            done = 1'b0;
            for (int c = 0; c < 300 && !done; c++) begin
                for (int o = 0; o < NP; o++) if (out_valid[o]) model_check(o, out_of(o));
                pending = 0;
                for (int q = 0; q < 9; q++) pending += sb[q].size();
                if (pending == 0 && out_valid == '0 && !has_flying_messages) done = 1'b1;
                else tick();
            end
            chk("drain_done", 64'(done), 64'h1);
            for (int q = 0; q < 9; q++) chk($sformatf("drain_q%0d", q), 64'(sb[q].size()), 64'h0);
            chk("rand_bad", 64'(bad_dest_error), 64'(bad_model));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
